// File: rtl/mips_pkg.sv
// Shared MIPS definitions: instruction field positions, fetch FSM encoding and constants.
package mips_pkg;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int SH_HI  = 10;
  localparam int SH_LO  = 6;
  localparam int FN_HI  = 5;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int JA_HI  = 25;
  localparam int JA_LO  = 0;

  localparam logic IDLE = 1'b0;
  localparam logic WAIT = 1'b1;

  typedef enum logic {
    S_IDLE = IDLE,
    S_WAIT = WAIT
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ir_fields.sv
// Combinational IR-to-field slicer, shared with the control decoder.
module ir_fields
  import mips_pkg::*;
(
  input  logic [31:0] ir,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr
);

  assign opcode = ir[OPC_HI:OPC_LO];
  assign rs     = ir[RS_HI:RS_LO];
  assign rt     = ir[RT_HI:RT_LO];
  assign rd     = ir[RD_HI:RD_LO];
  assign shamt  = ir[SH_HI:SH_LO];
  assign funct  = ir[FN_HI:FN_LO];
  assign imm16  = ir[IMM_HI:IMM_LO];
  assign jaddr  = ir[JA_HI:JA_LO];

endmodule

// File: rtl/ir_fetch_unit.sv
// Multicycle MIPS fetch stage: issues a word fetch, waits for the memory handshake
// with a timeout, and holds the IR and MDR.
module ir_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned  TIMEOUT_CYCLES = 16,
  parameter logic [31:0]  RESET_INSTR    = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_start,
  input  logic        flush,
  input  logic [31:0] pc_in,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        mdr_load,
  output logic [31:0] mdr_out,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  shamt,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] jaddr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic        busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      ir_q, ir_d;
  logic [31:0]      mdr_q, mdr_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;

  // Next-state logic; WAIT resolves flush before ready before timeout.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    mdr_d   = mdr_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mdr_load) begin
          mdr_d = mem_rdata;
        end else begin
          mdr_d = mdr_q;
        end
        if (fetch_start) begin
          if (is_word_aligned(pc_in)) begin
            addr_d  = pc_in;
            cnt_d   = '0;
            state_d = S_WAIT;
          end else begin
            err_d   = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (mem_ready) begin
          ir_d    = mem_rdata;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, IR, MDR, address, timeout counter and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ir_q    <= RESET_INSTR;
      mdr_q   <= 32'h0000_0000;
      addr_q  <= 32'h0000_0000;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      mdr_q   <= mdr_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign mem_req     = (state_q == S_WAIT);
  assign busy        = (state_q == S_WAIT);
  assign mem_addr    = addr_q;
  assign mdr_out     = mdr_q;
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

  ir_fields u_fields (
    .ir     (ir_q),
    .opcode (opcode),
    .rs     (rs),
    .rt     (rt),
    .rd     (rd),
    .shamt  (shamt),
    .funct  (funct),
    .imm16  (imm16),
    .jaddr  (jaddr)
  );

endmodule

// File: tb/tb_ir_fetch_unit.sv
// Directed bench for ir_fetch_unit with a transaction-level reference model.
module tb_ir_fetch_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_in = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  logic        mdr_load = 1'b0;
  logic [31:0] mdr_out;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm16;
  logic [25:0] jaddr;
  logic        instr_valid, fetch_err, busy;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  bit chk_en = 1'b0;

  ir_fetch_unit #(.TIMEOUT_CYCLES(TMO), .RESET_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_start(fetch_start), .flush(flush),
    .pc_in(pc_in), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mdr_load(mdr_load),
    .mdr_out(mdr_out), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm16(imm16), .jaddr(jaddr),
    .instr_valid(instr_valid), .fetch_err(fetch_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a fetch is "outstanding" with an age in cycles.
  bit          m_busy;
  int          m_age;
  logic [31:0] m_ir, m_mdr, m_addr;
  bit          m_valid, m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_age <= 0; m_ir <= 32'h0; m_mdr <= 32'h0;
      m_addr <= 32'h0; m_valid <= 1'b0; m_err <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      m_err   <= 1'b0;
      if (!m_busy) begin
        if (mdr_load) m_mdr <= mem_rdata;
        if (fetch_start) begin
          if (pc_in % 4 == 0) begin
            m_busy <= 1'b1; m_addr <= pc_in; m_age <= 0;
          end else begin
            m_err <= 1'b1;
          end
        end
      end else begin
        m_age <= m_age + 1;
        if (flush) m_busy <= 1'b0;
        else if (mem_ready) begin
          m_ir <= mem_rdata; m_valid <= 1'b1; m_busy <= 1'b0;
        end else if (m_age + 1 >= TMO) begin
          m_busy <= 1'b0; m_err <= 1'b1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("mem_req", {31'h0, mem_req}, {31'h0, m_busy});
      chk("busy", {31'h0, busy}, {31'h0, m_busy});
      chk("mem_addr", mem_addr, m_addr);
      chk("mdr_out", mdr_out, m_mdr);
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_valid});
      chk("fetch_err", {31'h0, fetch_err}, {31'h0, m_err});
      chk("opcode", {26'h0, opcode}, {26'h0, m_ir[31:26]});
      chk("rs", {27'h0, rs}, {27'h0, m_ir[25:21]});
      chk("rt", {27'h0, rt}, {27'h0, m_ir[20:16]});
      chk("rd", {27'h0, rd}, {27'h0, m_ir[15:11]});
      chk("shamt", {27'h0, shamt}, {27'h0, m_ir[10:6]});
      chk("funct", {26'h0, funct}, {26'h0, m_ir[5:0]});
      chk("imm16", {16'h0, imm16}, {16'h0, m_ir[15:0]});
      chk("jaddr", {6'h0, jaddr}, {6'h0, m_ir[25:0]});
      chk("valid_err_excl", {31'h0, instr_valid & fetch_err}, 32'h0);
    end
    if (mem_req === 1'b1) busy_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    // Reset state
    chk("rst_opcode", {26'h0, opcode}, 32'h0);
    chk("rst_funct", {26'h0, funct}, 32'h0);
    chk("rst_imm16", {16'h0, imm16}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_mdr", mdr_out, 32'h0);

    // Basic fetch: ready arrives on the third WAIT edge
    busy_cnt = 0;
    pc_in = 32'h0000_0040; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    step();
    step();
    mem_ready = 1'b1; mem_rdata = 32'h2008_FFFC;
    step();
    mem_ready = 1'b0;
    chk("basic_valid", {31'h0, instr_valid}, 32'h1);
    chk("basic_busy_cycles", busy_cnt, 32'd3);
    chk("basic_addr", mem_addr, 32'h0000_0040);
    chk("basic_opcode", {26'h0, opcode}, 32'h08);
    chk("basic_rs", {27'h0, rs}, 32'h0);
    chk("basic_rt", {27'h0, rt}, 32'd8);
    chk("basic_imm16", {16'h0, imm16}, 32'h0000_FFFC);
    chk("basic_funct", {26'h0, funct}, 32'h3C);
    step();
    chk("basic_valid_pulse", {31'h0, instr_valid}, 32'h0);

    // Misaligned PC
    busy_cnt = 0;
    pc_in = 32'h0000_0042; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    chk("mis_err", {31'h0, fetch_err}, 32'h1);
    chk("mis_req", {31'h0, mem_req}, 32'h0);
    chk("mis_opcode", {26'h0, opcode}, 32'h08);
    step();
    chk("mis_err_pulse", {31'h0, fetch_err}, 32'h0);
    chk("mis_busy_cycles", busy_cnt, 32'd0);

    // Timeout, with an ignored fetch_start while waiting
    busy_cnt = 0;
    pc_in = 32'h0000_0100; fetch_start = 1'b1;
    step();
    pc_in = 32'h0000_0200;
    step();
    fetch_start = 1'b0;
    for (int i = 0; i < 20 && fetch_err !== 1'b1; i++) step();
    chk("tmo_err_seen", {31'h0, fetch_err}, 32'h1);
    chk("tmo_busy_cycles", busy_cnt, TMO);
    chk("tmo_addr", mem_addr, 32'h0000_0100);
    chk("tmo_imm16", {16'h0, imm16}, 32'h0000_FFFC);
    step();

    // Flush wins over ready
    pc_in = 32'h0000_0080; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    flush = 1'b1; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    flush = 1'b0; mem_ready = 1'b0;
    chk("flush_valid", {31'h0, instr_valid}, 32'h0);
    chk("flush_req", {31'h0, mem_req}, 32'h0);
    chk("flush_opcode", {26'h0, opcode}, 32'h08);
    step();

    // Minimum-latency fetch of lw $10,16($2)
    pc_in = 32'h0000_0084; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h8C4A_0010;
    step();
    mem_ready = 1'b0;
    chk("lw_valid", {31'h0, instr_valid}, 32'h1);
    chk("lw_opcode", {26'h0, opcode}, 32'h23);
    chk("lw_rs", {27'h0, rs}, 32'd2);
    chk("lw_rt", {27'h0, rt}, 32'd10);
    chk("lw_imm16", {16'h0, imm16}, 32'h0000_0010);
    chk("lw_jaddr", {6'h0, jaddr}, 32'h004A_0010);
    step();

    // MDR load in IDLE, ignored in WAIT
    mdr_load = 1'b1; mem_rdata = 32'h1234_5678;
    step();
    mdr_load = 1'b0;
    chk("mdr_load", mdr_out, 32'h1234_5678);
    pc_in = 32'h0000_0088; fetch_start = 1'b1;
    step();
    fetch_start = 1'b0;
    mdr_load = 1'b1; mem_rdata = 32'hCAFE_F00D;
    step();
    mdr_load = 1'b0;
    chk("mdr_wait_ignored", mdr_out, 32'h1234_5678);
    chk("mdr_still_busy", {31'h0, busy}, 32'h1);

    // Asynchronous reset in WAIT
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'h0, mem_req}, 32'h0);
    chk("arst_opcode", {26'h0, opcode}, 32'h0);
    chk("arst_imm16", {16'h0, imm16}, 32'h0);
    chk("arst_mdr", mdr_out, 32'h0);
    chk("arst_addr", mem_addr, 32'h0);
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    mem_ready = 1'b0;
    rst_n = 1'b1;
    step();
    step();
    chk("post_rst_idle", {31'h0, busy}, 32'h0);
    chk("post_rst_opcode", {26'h0, opcode}, 32'h0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
